// File: rtl/vote_input_conditioner_if.sv
// Board-input bundle for the vote front-end: raw active-low switches in, clean levels/pulses out.
// Latency: none, wires only.
// Backpressure: none; levels are sampled continuously and pulses are fire-and-forget.
interface vote_input_conditioner_if #(
    parameter int ID_W = 8
);
    logic [2:0]      btn_raw_n;
    logic            mode_raw_n;
    logic            pollsig_raw_n;
    logic [ID_W-1:0] voter_id_raw_n;
    logic [2:0]      btn_level;
    logic [2:0]      btn_pulse;
    logic            mode_level;
    logic            pollsig_level;
    logic [ID_W-1:0] voter_id;
    logic            id_stable;
    logic            multi_press;

    // Board / stimulus side: drives the raw inputs, observes conditioned outputs.
    modport master (
        output btn_raw_n, mode_raw_n, pollsig_raw_n, voter_id_raw_n,
        input  btn_level, btn_pulse, mode_level, pollsig_level, voter_id, id_stable, multi_press
    );

    // Conditioner side.
    modport slave (
        input  btn_raw_n, mode_raw_n, pollsig_raw_n, voter_id_raw_n,
        output btn_level, btn_pulse, mode_level, pollsig_level, voter_id, id_stable, multi_press
    );
endinterface

// File: rtl/vote_input_conditioner.sv
// Synchronise + debounce board switches, stabilise the voter ID, and arbitrate candidate buttons.
// Latency: raw edge to level is 2 + DEBOUNCE_CYCLES clocks; accepted-press pulse one clock later.
// Backpressure: none; a press is either accepted as a single pulse or dropped (conflict / unstable ID).
module vote_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20,
    parameter int ID_W            = 8
) (
    input  logic clock,
    input  logic reset,
    vote_input_conditioner_if.slave bus
);
    // Scalar signals debounced side by side: [2:0] buttons, [3] mode, [4] poll.
    localparam int NSIG = 5;
    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HELD    = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    logic [NSIG-1:0]            w_raw_inv;
    logic [NSIG-1:0]            r_sync1;
    logic [NSIG-1:0]            r_sync2;
    logic [NSIG-1:0]            r_level;
    logic [NSIG-1:0][CNT_W-1:0] r_cnt;

    logic [ID_W-1:0]  r_id_sync1;
    logic [ID_W-1:0]  r_id_sync2;
    logic [ID_W-1:0]  r_id_prev;
    logic [ID_W-1:0]  r_voter_id;
    logic [CNT_W-1:0] r_id_cnt;
    logic             w_id_stable;

    logic [2:0] w_btn;
    logic       w_btn_any;
    logic       w_btn_multi;
    state_t     r_state;
    logic [2:0] r_btn_pulse;
    logic       r_multi_press;

    assign w_raw_inv = ~{bus.pollsig_raw_n, bus.mode_raw_n, bus.btn_raw_n};

    // Two-flop synchronisers on the inverted (active-high) board inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_id_sync1 <= '0;
            r_id_sync2 <= '0;
        end else begin
            r_sync1    <= w_raw_inv;
            r_sync2    <= r_sync1;
            r_id_sync1 <= ~bus.voter_id_raw_n;
            r_id_sync2 <= r_id_sync1;
        end
    end

    // Per-signal debounce: level follows s only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_level <= '0;
            r_cnt   <= '0;
        end else begin
            for (int i = 0; i < NSIG; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LP_CNT_MAX) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + LP_CNT_ONE;
                end
            end
        end
    end

    // Whole-bus ID debounce; adoption also needs the bus unchanged this cycle so a
    // saturated counter never lets the first edge of a new value straight through.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_id_prev  <= '0;
            r_id_cnt   <= '0;
            r_voter_id <= '0;
        end else begin
            r_id_prev <= r_id_sync2;
            if (r_id_sync2 != r_id_prev) begin
                r_id_cnt <= '0;
            end else if (r_id_cnt != LP_CNT_MAX) begin
                r_id_cnt <= r_id_cnt + LP_CNT_ONE;
            end
            if ((r_id_cnt == LP_CNT_MAX) && (r_id_sync2 == r_id_prev) && (r_id_sync2 != r_voter_id)) begin
                r_voter_id <= r_id_sync2;
            end
        end
    end

    assign w_id_stable = (r_id_sync2 == r_voter_id);

    assign w_btn       = r_level[2:0];
    assign w_btn_any   = |w_btn;
    assign w_btn_multi = (w_btn[0] & w_btn[1]) | (w_btn[0] & w_btn[2]) | (w_btn[1] & w_btn[2]);

    // Press arbitration: one pulse per clean single press, conflicts latch until full release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_btn_pulse   <= '0;
            r_multi_press <= 1'b0;
        end else begin
            r_btn_pulse <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_btn_multi) begin
                        r_multi_press <= 1'b1;
                        r_state       <= ST_BLOCKED;
                    end else if (w_btn_any) begin
                        if (w_id_stable) begin
                            r_btn_pulse <= w_btn;
                        end
                        r_state <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (w_btn_multi) begin
                        r_multi_press <= 1'b1;
                        r_state       <= ST_BLOCKED;
                    end else if (!w_btn_any) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BLOCKED: begin
                    if (!w_btn_any) begin
                        r_multi_press <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_multi_press <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.btn_level     = r_level[2:0];
    assign bus.mode_level    = r_level[3];
    assign bus.pollsig_level = r_level[4];
    assign bus.voter_id      = r_voter_id;
    assign bus.id_stable     = w_id_stable;
    assign bus.btn_pulse     = r_btn_pulse;
    assign bus.multi_press   = r_multi_press;
endmodule

// File: tb/tb_vote_input_conditioner.sv
// Directed bench for vote_input_conditioner: table of steady-state vectors plus timed corner sequences.
// Latency: checks exact debounce timing (level at raw+18, pulse at raw+19, ID adopt at last change+19).
// Backpressure: n/a; pulses are counted and checked for one-hot and non-consecutive.
module tb_vote_input_conditioner;
    localparam int ID_W = 8;
    localparam int NV   = 16;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    vote_input_conditioner_if #(.ID_W(ID_W)) bus ();

    vote_input_conditioner #(
        .DEBOUNCE_CYCLES(16),
        .CNT_W          (20),
        .ID_W           (ID_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [2:0]      btn_n;
        logic            mode_n;
        logic            poll_n;
        logic [ID_W-1:0] id_n;
        int              wait_cyc;
        logic [2:0]      e_lvl;
        logic            e_mode;
        logic            e_poll;
        logic [ID_W-1:0] e_vid;
        logic            e_stab;
        logic            e_multi;
        int              e_pcnt;
        logic [2:0]      e_por;
    } vec_t;

    vec_t tbl [NV];

    int         vectors     = 0;
    int         miscompares = 0;
    int         pulse_cnt;
    int         pulse_bad;
    int         stab_bad;
    logic [2:0] pulse_or;
    logic [2:0] pulse_prev;
    logic [2:0] lvl_seen;
    logic       mode_seen;

    // One clock: sample 1 time unit after the rising edge, then return so the caller may drive.
    task automatic tick();
        @(posedge clock);
        #1;
        if (bus.btn_pulse != 3'b000) begin
            pulse_cnt++;
            pulse_or = pulse_or | bus.btn_pulse;
            if (pulse_prev != 3'b000) pulse_bad++;
            if (!$onehot(bus.btn_pulse)) pulse_bad++;
        end
        pulse_prev = bus.btn_pulse;
        lvl_seen   = lvl_seen | bus.btn_level;
        mode_seen  = mode_seen | bus.mode_level;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_mon();
        pulse_cnt = 0;
        pulse_bad = 0;
        pulse_or  = 3'b000;
        lvl_seen  = 3'b000;
        mode_seen = 1'b0;
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [2:0] e_lvl, input logic e_mode,
                             input logic e_poll, input logic [ID_W-1:0] e_vid, input logic e_stab,
                             input logic e_multi, input int e_pcnt, input logic [2:0] e_por);
        vectors++;
        if (bus.btn_level !== e_lvl || bus.mode_level !== e_mode || bus.pollsig_level !== e_poll ||
            bus.voter_id !== e_vid || bus.id_stable !== e_stab || bus.multi_press !== e_multi ||
            pulse_cnt != e_pcnt || pulse_or !== e_por || pulse_bad != 0) begin
            miscompares++;
            $display("FAIL %s: got lvl=%b mode=%b poll=%b vid=%h stab=%b multi=%b pulses=%0d/%b bad=%0d; want lvl=%b mode=%b poll=%b vid=%h stab=%b multi=%b pulses=%0d/%b bad=0",
                     name, bus.btn_level, bus.mode_level, bus.pollsig_level, bus.voter_id, bus.id_stable,
                     bus.multi_press, pulse_cnt, pulse_or, pulse_bad,
                     e_lvl, e_mode, e_poll, e_vid, e_stab, e_multi, e_pcnt, e_por);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //         btn_n   mode  poll  id_n    wait  lvl     mode  poll  vid     stab  multi pcnt por
        tbl[0]  = '{3'b111, 1'b1, 1'b1, 8'hFF, 40, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 3'b000};
        tbl[1]  = '{3'b101, 1'b1, 1'b1, 8'hFF, 25, 3'b010, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 3'b010};
        tbl[2]  = '{3'b111, 1'b1, 1'b1, 8'hFF, 25, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 3'b000};
        tbl[3]  = '{3'b101, 1'b1, 1'b1, 8'hFF, 25, 3'b010, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 3'b010};
        tbl[4]  = '{3'b111, 1'b1, 1'b1, 8'hFF, 25, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 3'b000};
        tbl[5]  = '{3'b111, 1'b0, 1'b1, 8'hFF, 25, 3'b000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 3'b000};
        tbl[6]  = '{3'b111, 1'b0, 1'b0, 8'hFF, 25, 3'b000, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0, 3'b000};
        tbl[7]  = '{3'b111, 1'b1, 1'b1, 8'hFF, 25, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 3'b000};
        tbl[8]  = '{3'b100, 1'b1, 1'b1, 8'hFF, 25, 3'b011, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0, 3'b000};
        tbl[9]  = '{3'b110, 1'b1, 1'b1, 8'hFF, 25, 3'b001, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0, 3'b000};
        tbl[10] = '{3'b111, 1'b1, 1'b1, 8'hFF, 25, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 3'b000};
        tbl[11] = '{3'b110, 1'b1, 1'b1, 8'hFF, 30, 3'b001, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 3'b001};
        tbl[12] = '{3'b010, 1'b1, 1'b1, 8'hFF, 25, 3'b101, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0, 3'b000};
        tbl[13] = '{3'b111, 1'b1, 1'b1, 8'hFF, 25, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 3'b000};
        tbl[14] = '{3'b111, 1'b1, 1'b1, 8'hF0, 40, 3'b000, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b0, 0, 3'b000};
        tbl[15] = '{3'b111, 1'b1, 1'b1, 8'hFF, 40, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 3'b000};

        pulse_prev = 3'b000;
        clear_mon();
        reset              = 1'b1;
        bus.btn_raw_n      = 3'b111;
        bus.mode_raw_n     = 1'b1;
        bus.pollsig_raw_n  = 1'b1;
        bus.voter_id_raw_n = 8'hFF;
        run(3);
        check_out("reset_state", 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 3'b000);
        check_eq("reset_pulse", 32'(bus.btn_pulse), 32'h0);
        reset = 1'b0;

        // Steady-state table.
        for (int i = 0; i < NV; i++) begin
            clear_mon();
            bus.btn_raw_n      = tbl[i].btn_n;
            bus.mode_raw_n     = tbl[i].mode_n;
            bus.pollsig_raw_n  = tbl[i].poll_n;
            bus.voter_id_raw_n = tbl[i].id_n;
            run(tbl[i].wait_cyc);
            check_out($sformatf("vec%0d", i), tbl[i].e_lvl, tbl[i].e_mode, tbl[i].e_poll, tbl[i].e_vid,
                      tbl[i].e_stab, tbl[i].e_multi, tbl[i].e_pcnt, tbl[i].e_por);
        end

        // Exact latency: level on the 18th edge after the raw change, pulse on the 19th only.
        clear_mon();
        bus.btn_raw_n = 3'b101;
        run(17);
        check_eq("lat_before", 32'(bus.btn_level), 32'h0);
        tick();
        check_eq("lat_level", 32'(bus.btn_level), 32'h2);
        check_eq("lat_no_pulse_yet", 32'(bus.btn_pulse), 32'h0);
        tick();
        check_eq("lat_pulse", 32'(bus.btn_pulse), 32'h2);
        tick();
        check_eq("lat_pulse_end", 32'(bus.btn_pulse), 32'h0);
        run(30);
        check_eq("lat_held_pulses", 32'(pulse_cnt), 32'd1);
        bus.btn_raw_n = 3'b111;
        run(25);

        // Short glitches rejected; a 16-cycle mode assertion gets through.
        clear_mon();
        bus.btn_raw_n = 3'b110;
        run(10);
        bus.btn_raw_n = 3'b111;
        run(30);
        check_eq("glitch_btn_level", 32'(lvl_seen), 32'h0);
        check_eq("glitch_btn_pulses", 32'(pulse_cnt), 32'd0);
        clear_mon();
        bus.mode_raw_n = 1'b0;
        run(15);
        bus.mode_raw_n = 1'b1;
        run(25);
        check_eq("glitch_mode15", 32'(mode_seen), 32'h0);
        clear_mon();
        bus.mode_raw_n = 1'b0;
        run(16);
        bus.mode_raw_n = 1'b1;
        run(25);
        check_eq("mode16_rose", 32'(mode_seen), 32'h1);
        check_eq("mode16_fell", 32'(bus.mode_level), 32'h0);

        // Unstable voter ID: press made during churn gives no pulse; ID adopted 19 edges after last change.
        clear_mon();
        stab_bad           = 0;
        bus.voter_id_raw_n = 8'hF5;
        bus.btn_raw_n      = 3'b011;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (t >= 2 && bus.id_stable) stab_bad++;
            if (t % 5 == 0) bus.voter_id_raw_n[0] = ~bus.voter_id_raw_n[0];
        end
        for (int t = 1; t <= 18; t++) begin
            tick();
            if (bus.id_stable) stab_bad++;
        end
        check_eq("id_unstable_count", 32'(stab_bad), 32'd0);
        check_eq("id_before_adopt", 32'(bus.voter_id), 32'h00);
        tick();
        check_eq("id_adopted", 32'(bus.voter_id), 32'h0A);
        check_eq("id_stable_after", 32'(bus.id_stable), 32'h1);
        check_eq("id_btn_level", 32'(bus.btn_level), 32'h4);
        check_eq("id_unstable_no_pulse", 32'(pulse_cnt), 32'd0);
        bus.btn_raw_n = 3'b111;
        run(25);
        clear_mon();
        bus.btn_raw_n = 3'b011;
        run(25);
        check_out("id_stable_press", 3'b100, 1'b0, 1'b0, 8'h0A, 1'b1, 1'b0, 1, 3'b100);
        bus.btn_raw_n      = 3'b111;
        bus.voter_id_raw_n = 8'hFF;
        run(40);

        // Reset while BLOCKED with two buttons held, then re-debounce into BLOCKED again.
        clear_mon();
        bus.btn_raw_n = 3'b100;
        run(25);
        check_eq("pre_rst_multi", 32'(bus.multi_press), 32'h1);
        reset = 1'b1;
        #2;
        check_eq("rst_multi_clear", 32'(bus.multi_press), 32'h0);
        check_eq("rst_level_clear", 32'(bus.btn_level), 32'h0);
        run(2);
        reset = 1'b0;
        clear_mon();
        run(25);
        check_out("rst_reblocked", 3'b011, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0, 3'b000);
        bus.btn_raw_n = 3'b111;
        run(25);
        check_eq("rst_unblock", 32'(bus.multi_press), 32'h0);

        // Reset while a single button is held: exactly one fresh pulse afterwards.
        clear_mon();
        bus.btn_raw_n = 3'b110;
        run(25);
        check_eq("pre_rst_single_pulses", 32'(pulse_cnt), 32'd1);
        reset = 1'b1;
        #2;
        check_eq("rst_single_level_clear", 32'(bus.btn_level), 32'h0);
        tick();
        reset = 1'b0;
        clear_mon();
        run(25);
        check_out("rst_single_repulse", 3'b001, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 3'b001);
        bus.btn_raw_n = 3'b111;
        run(25);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
